// File: rtl/mms_stream.sv
// ----------------------------------------------------------------------------
// mms_stream
//
// Streaming min/max selector. Accepts one WIDTH-bit sample per cycle over a
// frame of up to NUM_IN samples and reports the frame's maximum (select=0) or
// minimum (select=1) together with the frame-relative index of that sample.
// Ties keep the earliest index. Frames end on in_last or after NUM_IN samples;
// a new frame may start in the cycle right after the completing sample.
//
// Parameters:
//   WIDTH   sample/result width in bits
//   NUM_IN  maximum samples per frame (>= 1)
//   SIGNED  0 = unsigned compare, 1 = two's-complement compare
//   IDX_W   derived index width, max(1, clog2(NUM_IN)); not overridable
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset, highest priority
//   in_valid    sample present (no backpressure, always accepted)
//   in_data     sample value
//   in_select   0 = max, 1 = min; sampled with the frame's first sample only
//   in_last     final sample of a short frame (qualified by in_valid)
//   out_valid   one-cycle pulse, frame result available
//   result      selected value of the last completed frame (held)
//   result_idx  index of the selected sample within its frame (held)
// ----------------------------------------------------------------------------
module mms_stream #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int SIGNED = 0,
    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select,
    input  logic             in_last,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [IDX_W-1:0] result_idx
);

    // count has to represent 0..NUM_IN, one more value than the index range
    localparam int               CNT_W    = $clog2(NUM_IN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_IN - 1);
    localparam bit               ONE_DEEP = (NUM_IN == 1);

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             done;
    logic             in_gt, in_lt, better;

    // Strict compare only, so an equal later sample never displaces the
    // stored one and the earliest index wins ties in both modes.
    always_comb begin
        if (SIGNED != 0) begin
            in_gt = $signed(in_data) > $signed(acc_q);
            in_lt = $signed(in_data) < $signed(acc_q);
        end else begin
            in_gt = in_data > acc_q;
            in_lt = in_data < acc_q;
        end
        better = mode_q ? in_lt : in_gt;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        count_d = count_q;
        mode_d  = mode_q;
        done    = 1'b0;

        if (in_valid) begin
            case (state_q)
                IDLE: begin
                    acc_d   = in_data;
                    idx_d   = '0;
                    mode_d  = in_select;
                    count_d = CNT_W'(1);
                    if (in_last || ONE_DEEP) begin
                        done    = 1'b1;
                        count_d = '0;
                    end else begin
                        state_d = ACC;
                    end
                end
                ACC: begin
                    if (better) begin
                        acc_d = in_data;
                        idx_d = count_q[IDX_W-1:0];
                    end
                    count_d = count_q + CNT_W'(1);
                    // Completion at NUM_IN is forced regardless of in_last.
                    if (in_last || (count_q == LAST_CNT)) begin
                        done    = 1'b1;
                        count_d = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            mode_q     <= 1'b0;
            out_valid  <= 1'b0;
            result     <= '0;
            result_idx <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
            out_valid <= done;
            // Next-state values already include the completing sample.
            if (done) begin
                result     <= acc_d;
                result_idx <= idx_d;
            end
        end
    end

endmodule

// File: tb/tb_mms_stream.sv
// ----------------------------------------------------------------------------
// tb_mms_stream
//
// Drives three mms_stream instances from one input stream:
//   u_dut : WIDTH=8, NUM_IN=4, unsigned
//   s_dut : WIDTH=8, NUM_IN=4, signed
//   o_dut : WIDTH=8, NUM_IN=1, unsigned
// A frame-level reference model collects each frame's samples and picks the
// extreme value with a plain scan once the frame closes.
// ----------------------------------------------------------------------------
module tb_mms_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_select;
    logic       in_last;

    logic       ov_u, ov_s, ov_1;
    logic [7:0] res_u, res_s, res_1;
    logic [1:0] idx_u, idx_s;
    logic [0:0] idx_1;

    always #5 clk = ~clk;

    mms_stream #(.WIDTH(8), .NUM_IN(4), .SIGNED(0)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_select(in_select), .in_last(in_last),
        .out_valid(ov_u), .result(res_u), .result_idx(idx_u)
    );

    mms_stream #(.WIDTH(8), .NUM_IN(4), .SIGNED(1)) s_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_select(in_select), .in_last(in_last),
        .out_valid(ov_s), .result(res_s), .result_idx(idx_s)
    );

    mms_stream #(.WIDTH(8), .NUM_IN(1), .SIGNED(0)) o_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_select(in_select), .in_last(in_last),
        .out_valid(ov_1), .result(res_1), .result_idx(idx_1)
    );

    logic [10:0] obs_u, obs_s;
    logic [9:0]  obs_1;
    assign obs_u = {ov_u, res_u, idx_u};
    assign obs_s = {ov_s, res_s, idx_s};
    assign obs_1 = {ov_1, res_1, idx_1};

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    int unsigned nn[3] = '{4, 4, 1};
    bit          sg[3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0]  msamp[3][4];
    int unsigned mlen[3];
    logic        mmode[3];
    logic        exp_v[3];
    logic [7:0]  exp_r[3];
    int unsigned exp_i[3];
    logic [10:0] exp_u, exp_s;
    logic [9:0]  exp_1;

    function automatic bit beats(input logic [7:0] a, input logic [7:0] b,
                                 input logic mode, input bit sgn);
        int va, vb;
        if (sgn) begin
            va = int'($signed(a));
            vb = int'($signed(b));
        end else begin
            va = int'(a);
            vb = int'(b);
        end
        return mode ? (va < vb) : (va > vb);
    endfunction

    task automatic model_pack();
        exp_u = {exp_v[0], exp_r[0], 2'(exp_i[0])};
        exp_s = {exp_v[1], exp_r[1], 2'(exp_i[1])};
        exp_1 = {exp_v[2], exp_r[2], 1'(exp_i[2])};
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mlen[k]  = 0;
            mmode[k] = 1'b0;
            exp_v[k] = 1'b0;
            exp_r[k] = 8'h00;
            exp_i[k] = 0;
        end
        model_pack();
    endtask

    task automatic model_step(input logic v, input logic [7:0] d,
                              input logic s, input logic l);
        int unsigned b;
        for (int k = 0; k < 3; k++) begin
            exp_v[k] = 1'b0;
            if (v) begin
                if (mlen[k] == 0) mmode[k] = s;
                msamp[k][mlen[k]] = d;
                mlen[k]++;
                if (l || (mlen[k] == nn[k])) begin
                    b = 0;
                    for (int unsigned i = 1; i < mlen[k]; i++)
                        if (beats(msamp[k][i], msamp[k][b], mmode[k], sg[k])) b = i;
                    exp_v[k] = 1'b1;
                    exp_r[k] = msamp[k][b];
                    exp_i[k] = b;
                    mlen[k]  = 0;
                end
            end
        end
        model_pack();
    endtask

    // One clock of stimulus; outputs are then sampled 1 ns after the edge.
    task automatic drive(input logic v, input logic [7:0] d,
                         input logic s, input logic l);
        in_valid  = v;
        in_data   = d;
        in_select = s;
        in_last   = l;
        model_step(v, d, s, l);
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_select = 1'b0; in_last = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (obs_u !== 11'h0) begin errors++; $display("FAIL reset_u got=%h want=000", obs_u); end
        checks++; if (obs_s !== 11'h0) begin errors++; $display("FAIL reset_s got=%h want=000", obs_s); end
        checks++; if (obs_1 !== 10'h0) begin errors++; $display("FAIL reset_1 got=%h want=000", obs_1); end
        reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (obs_u !== exp_u) begin errors++; $display("FAIL idle_u got=%h want=%h", obs_u, exp_u); end
    endtask

    task automatic test_max_tie();
        logic [7:0] smp[4] = '{8'd3, 8'd200, 8'd17, 8'd200};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, smp[i], 1'b0, 1'b0);
            checks++; if (obs_u !== exp_u) begin errors++; $display("FAIL max_tie_u[%0d] got=%h want=%h", i, obs_u, exp_u); end
            checks++; if (obs_s !== exp_s) begin errors++; $display("FAIL max_tie_s[%0d] got=%h want=%h", i, obs_s, exp_s); end
            checks++; if (obs_1 !== exp_1) begin errors++; $display("FAIL max_tie_1[%0d] got=%h want=%h", i, obs_1, exp_1); end
        end
        checks++; if ({ov_u, res_u, idx_u} !== {1'b1, 8'd200, 2'd1}) begin
            errors++; $display("FAIL max_tie_const got=%b/%0d/%0d want=1/200/1", ov_u, res_u, idx_u); end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (ov_u !== 1'b0) begin errors++; $display("FAIL max_tie_pulse got=%b want=0", ov_u); end
    endtask

    task automatic test_min_select_ignored();
        logic [7:0] smp[4] = '{8'd3, 8'd200, 8'd17, 8'd200};
        logic [7:0] sm2[4] = '{8'd50, 8'd10, 8'd90, 8'd10};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, smp[i], 1'b1, 1'b0);
            checks++; if (obs_u !== exp_u) begin errors++; $display("FAIL min_u[%0d] got=%h want=%h", i, obs_u, exp_u); end
            checks++; if (obs_s !== exp_s) begin errors++; $display("FAIL min_s[%0d] got=%h want=%h", i, obs_s, exp_s); end
        end
        checks++; if ({res_u, idx_u} !== {8'd3, 2'd0}) begin
            errors++; $display("FAIL min_const got=%0d/%0d want=3/0", res_u, idx_u); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, sm2[i], i[0], 1'b0);
            checks++; if (obs_u !== exp_u) begin errors++; $display("FAIL selflip_u[%0d] got=%h want=%h", i, obs_u, exp_u); end
            checks++; if (obs_1 !== exp_1) begin errors++; $display("FAIL selflip_1[%0d] got=%h want=%h", i, obs_1, exp_1); end
        end
        checks++; if ({ov_u, res_u, idx_u} !== {1'b1, 8'd90, 2'd2}) begin
            errors++; $display("FAIL selflip_const got=%b/%0d/%0d want=1/90/2", ov_u, res_u, idx_u); end
    endtask

    task automatic test_signed();
        logic [7:0] smp[4] = '{8'h80, 8'h7F, 8'hFF, 8'h00};
        logic [9:0] want_s[2] = '{{8'h7F, 2'd1}, {8'h80, 2'd0}};
        logic [9:0] want_u[2] = '{{8'hFF, 2'd2}, {8'h00, 2'd3}};
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) begin
                drive(1'b1, smp[i], m[0], 1'b0);
                checks++; if (obs_s !== exp_s) begin errors++; $display("FAIL signed_s[%0d][%0d] got=%h want=%h", m, i, obs_s, exp_s); end
                checks++; if (obs_u !== exp_u) begin errors++; $display("FAIL signed_u[%0d][%0d] got=%h want=%h", m, i, obs_u, exp_u); end
            end
            checks++; if ({res_s, idx_s} !== want_s[m]) begin
                errors++; $display("FAIL signed_const_s[%0d] got=%h want=%h", m, {res_s, idx_s}, want_s[m]); end
            checks++; if ({res_u, idx_u} !== want_u[m]) begin
                errors++; $display("FAIL signed_const_u[%0d] got=%h want=%h", m, {res_u, idx_u}, want_u[m]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] smp[6] = '{8'd9, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        logic       prev = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, smp[i], (i < 2), (i == 1));
            checks++; if (obs_u !== exp_u) begin errors++; $display("FAIL b2b_u[%0d] got=%h want=%h", i, obs_u, exp_u); end
            checks++; if (obs_s !== exp_s) begin errors++; $display("FAIL b2b_s[%0d] got=%h want=%h", i, obs_s, exp_s); end
            checks++; if (prev && ov_u) begin errors++; $display("FAIL b2b_double[%0d] got=1 want=0", i); end
            prev = ov_u;
            if (i == 1) begin
                checks++; if ({ov_u, res_u, idx_u} !== {1'b1, 8'd4, 2'd1}) begin
                    errors++; $display("FAIL b2b_first got=%b/%0d/%0d want=1/4/1", ov_u, res_u, idx_u); end
            end
        end
        checks++; if ({ov_u, res_u, idx_u} !== {1'b1, 8'd8, 2'd3}) begin
            errors++; $display("FAIL b2b_second got=%b/%0d/%0d want=1/8/3", ov_u, res_u, idx_u); end
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(i + 1), 1'b0, 1'b0);
            checks++; if (obs_u !== exp_u) begin errors++; $display("FAIL gap_u[%0d] got=%h want=%h", i, obs_u, exp_u); end
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    drive(1'b0, 8'hEE, 1'b1, 1'b1);
                    checks++; if (obs_u !== exp_u) begin errors++; $display("FAIL gap_idle_u[%0d] got=%h want=%h", i, obs_u, exp_u); end
                end
            end
        end
        checks++; if ({ov_u, res_u, idx_u} !== {1'b1, 8'd4, 2'd3}) begin
            errors++; $display("FAIL gap_const got=%b/%0d/%0d want=1/4/3", ov_u, res_u, idx_u); end
        for (int g = 0; g < 5; g++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0);
            checks++; if ({ov_u, res_u, idx_u} !== {1'b0, 8'd4, 2'd3}) begin
                errors++; $display("FAIL gap_hold[%0d] got=%b/%0d/%0d want=0/4/3", g, ov_u, res_u, idx_u); end
        end
    endtask

    task automatic test_reset_midframe();
        drive(1'b1, 8'd11, 1'b0, 1'b0);
        drive(1'b1, 8'd99, 1'b0, 1'b0);
        reset = 1'b1; in_valid = 1'b1; in_data = 8'd200; in_last = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (obs_u !== 11'h0) begin errors++; $display("FAIL midreset_u got=%h want=000", obs_u); end
        checks++; if (obs_s !== 11'h0) begin errors++; $display("FAIL midreset_s got=%h want=000", obs_s); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'd7, 1'b1, 1'b0);
            checks++; if (obs_u !== exp_u) begin errors++; $display("FAIL after_reset_u[%0d] got=%h want=%h", i, obs_u, exp_u); end
        end
        checks++; if ({ov_u, res_u, idx_u} !== {1'b1, 8'd7, 2'd0}) begin
            errors++; $display("FAIL after_reset_const got=%b/%0d/%0d want=1/7/0", ov_u, res_u, idx_u); end
    endtask

    task automatic test_random();
        logic       v, s, l;
        logic [7:0] d;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 4) == 0);
            s = 1'($urandom);
            // narrow value range makes ties frequent
            d = (n[0]) ? 8'($urandom) : 8'($urandom_range(0, 3)) ^ 8'h7E;
            drive(v, d, s, l);
            checks++; if (obs_u !== exp_u) begin errors++; $display("FAIL rand_u[%0d] got=%h want=%h", n, obs_u, exp_u); end
            checks++; if (obs_s !== exp_s) begin errors++; $display("FAIL rand_s[%0d] got=%h want=%h", n, obs_s, exp_s); end
            checks++; if (obs_1 !== exp_1) begin errors++; $display("FAIL rand_1[%0d] got=%h want=%h", n, obs_1, exp_1); end
        end
    endtask

    initial begin
        test_reset();
        test_max_tie();
        test_min_select_ignored();
        test_signed();
        test_back_to_back();
        test_gaps();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mms_stream.md
Name: mms_stream

Overview:
Streaming min/max selector and the parametrised successor of the fixed 4-input combinational MMS block. It accepts one WIDTH-bit sample per cycle over a frame of up to NUM_IN samples and reports the frame's maximum (select=0) or minimum (select=1) together with that sample's index. It supports signed or unsigned compare, early frame termination and back-to-back frames. It sits between a sample source and a downstream consumer, in the same datapath slot the combinational block occupied.

Parameters:
WIDTH, 8, sample and result width in bits.
NUM_IN, 4, maximum samples per frame (>=1). IDX_W = max(1, $clog2(NUM_IN)) is a derived localparam and is not overridable.
SIGNED, 0, 0 = unsigned compare; 1 = two's-complement compare.

Ports:
clk  input  1  clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  sample present this cycle; there is no backpressure, so every valid sample is accepted.
in_data  input  WIDTH  sample value.
in_select  input  1  0 = max, 1 = min; sampled only with the first sample of a frame.
in_last  input  1  qualified by in_valid; marks the final sample of a short frame.
out_valid  output  1  one-cycle pulse; the frame result is available.
result  output  WIDTH  selected min or max value of the last completed frame.
result_idx  output  IDX_W  frame-relative index (0-based) of the selected sample.

Behaviour:
- Reset (synchronous, active-high, at the clk edge while reset=1):
  - out_valid=0, result=0, result_idx=0.
  - Internal state goes to IDLE; count=0; accumulator cleared.
  - reset has priority over all inputs.
- State IDLE (no frame open), on in_valid=1:
  - Store acc=in_data, acc_idx=0, mode=in_select, count=1.
  - If in_last=1 or NUM_IN==1, the frame completes this cycle and the state stays IDLE.
  - Otherwise go to ACC.
- State ACC, on in_valid=1:
  - Compare in_data against acc using mode and SIGNED.
  - Replace acc and acc_idx=count only when strictly better: greater for max, less for min.
  - On ties the earliest index wins, in both modes.
  - count increments.
  - The frame completes when in_last=1 or when this is sample number NUM_IN (count==NUM_IN-1 before increment). The state then returns to IDLE.
- in_valid=0 in any state: a gap. State, count and acc hold; gaps are allowed anywhere mid-frame.
- in_select changes mid-frame are ignored. in_last is ignored when in_valid=0.
- Latency:
  - out_valid=1 in the cycle after the completing sample is accepted, for exactly one cycle.
  - result and result_idx are updated in that same cycle to the final frame outcome, including the completing sample's contribution.
  - result and result_idx hold until the next out_valid.
- Back-to-back frames: a new frame's first sample may arrive in the cycle immediately after the completing sample (i.e. while out_valid=1). It is accepted as a normal IDLE first sample; zero bubbles are required.
- Comparison:
  - The compare is WIDTH bits wide with no extension outside the compare.
  - SIGNED=1 treats the MSB as the sign bit.
- Reset mid-frame: the partial frame is discarded, no out_valid is produced, and the prior result is cleared to 0.
- count never exceeds NUM_IN. Completion at NUM_IN is forced even when in_last=0.

Test Plan:
1. NUM_IN=4, unsigned, select=0, samples 3,200,17,200 on consecutive cycles -> out_valid the cycle after sample 3 (index 3), result=200, result_idx=1 (tie, earliest wins).
2. Same samples with select=1 -> result=3, result_idx=0. Then toggle in_select high/low mid-frame on a new frame 50,10,90,10 with select=0 at first sample -> result=90, result_idx=2.
3. Samples 8'h80,8'h7F,8'hFF,8'h00, under four configurations:
   - SIGNED=1, max -> 8'h7F, idx 1.
   - SIGNED=1, min -> 8'h80, idx 0.
   - SIGNED=0, max -> 8'hFF, idx 2.
   - SIGNED=0, min -> 8'h00, idx 3.
4. Short frame 9,4 with in_last on 4, select=1, followed next cycle with no bubble by frame 5,6,7,8 select=0:
   - First out_valid -> result=4, result_idx=1.
   - Second out_valid exactly 4 cycles later -> result=8, result_idx=3.
   - out_valid is never high for two consecutive cycles.
5. Frame 1,2,3,4 with in_valid=0 gaps of 2 cycles between samples, select=0 -> single out_valid one cycle after the 4th sample, result=4, result_idx=3. Result holds unchanged through a following idle period.
6. Assert reset for one cycle after 2 samples of a frame -> no out_valid, result=0, result_idx=0. The next full frame 7,7,7,7 with select=1 -> result=7, result_idx=0.
